data_cache: RTL and testbench
=============================

Name: data_cache

Overview:
- Direct-mapped, write-through, write-allocate L1 data cache between the MEM pipeline stage and the 20-cycle-latency data memory.
- Serves load hits combinationally in the access cycle.
- Freezes the pipeline with Stall while a block fill or write-through is outstanding.
- Memory-side interface matches the data memory's ReadMiss / MemWriteThrough / ReadReady / WriteReady handshake and its 4-word block read.

Parameters:
- NUM_SETS, 8, number of lines (power of 2).
- BLOCK_SIZE, 4, words per line; must equal the data memory's BLOCK_SIZE.

Ports:
- Clk  in  1  clock.
- Rst  in  1  synchronous active-high reset.
- Address  in  32  byte address from MEM stage, word aligned.
- MemRead  in  1  load request.
- MemWrite  in  1  store request.
- WriteData  in  32  store data.
- ReadData  out  32  load data, valid when MemRead && !Stall.
- Stall  out  1  freeze pipeline.
- MemAddress  out  32  address to data memory.
- MemReadMiss  out  1  block-fill request (ReadMiss).
- MemWriteThrough  out  1  word-write request.
- MemWriteData  out  32  word to write.
- MemReadData  in  32*BLOCK_SIZE  returned block, word i at bits [32i+31:32i].
- MemReadReady  in  1  fill complete (one-cycle pulse).
- MemWriteReady  in  1  write complete (one-cycle pulse).

Behaviour:
- Address fields:
  - offset = Address[log2(BLOCK_SIZE)+1:2]
  - index = next log2(NUM_SETS) bits
  - tag = remaining upper bits
  - Address[1:0] ignored.
- Per line storage: valid, tag, BLOCK_SIZE words. hit = valid[index] && tag match.
- States: IDLE, FILL, WRITE, FILL_WRITE, RESUME.
- Reset (synchronous, Rst high at Clk edge):
  - all valid bits cleared; state = IDLE.
  - MemReadMiss = MemWriteThrough = Stall = 0; ReadData = 0.
  - Rst mid-operation aborts immediately; requests drop the following cycle; a late Ready pulse is ignored in IDLE.
- IDLE:
  - Load hit: ReadData = line word[offset] combinationally; Stall = 0; no state change.
  - Load miss: Stall = 1 combinationally; next state FILL.
  - Store hit: word[offset] <= WriteData at the edge; Stall = 1; next state WRITE.
  - Store miss: Stall = 1; next state FILL_WRITE.
  - MemRead && MemWrite together: store takes priority.
  - Neither asserted: Stall = 0, ReadData = 0.
- FILL:
  - MemReadMiss held high, MemAddress = latched Address, Stall = 1.
  - On MemReadReady: write MemReadData into line, set valid, write tag; next state RESUME.
- WRITE:
  - MemWriteThrough held high, MemAddress = latched Address, MemWriteData = latched WriteData, Stall = 1.
  - On MemWriteReady: next state RESUME.
- FILL_WRITE:
  - MemReadMiss and MemWriteThrough both high; memory performs fill plus word write.
  - On MemReadReady: install block with word[offset] replaced by latched WriteData; next state RESUME.
- RESUME:
  - Stall = 1 for one cycle (memory returns to IDLE); next state IDLE.
  - In IDLE the stalled instruction is replayed and hits.
- Request outputs:
  - Registered, high for the whole outstanding period.
  - Deasserted in the cycle after Ready.
  - Never re-asserted in RESUME.
- Address, WriteData and the request type are latched on leaving IDLE; pipeline changes while stalled are ignored.
- Load miss latency to data: memory latency + 2 cycles. Store hit: Stall high for memory latency + 2 cycles.
- Conflict miss: line overwritten unconditionally; no writeback needed (write-through).

Optional Feature:
- DCACHE_STATS_EN defined:
  - adds outputs HitCount [31:0] and MissCount [31:0].
  - each counts IDLE-state accesses by outcome, once per instruction; replay hits after RESUME are not counted.
  - counters reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package dcache_pkg: state encoding, derived widths (OFFSET_W, INDEX_W, TAG_W), LINE_W = 32*BLOCK_SIZE.
- Sub-module dcache_line_array holds valid/tag/data storage:
  - asynchronous read by index.
  - synchronous full-line fill and single-word write ports.
  - synchronous valid clear on Rst.
- data_cache keeps the FSM and hit logic.

Test Plan:
- Load miss at 0x24, memory word 0x24 = 0x11112222 -> Stall high, MemReadMiss high with MemAddress 0x24 until MemReadReady; two cycles later Stall low, ReadData = 0x11112222.
- Load 0x20 immediately after -> same-cycle hit, Stall 0, ReadData = memory word 0x20, no memory request.
- Store 0xDEADBEEF to 0x28 (hit) -> MemWriteThrough high, MemWriteData 0xDEADBEEF until MemWriteReady; subsequent load 0x28 hits and returns 0xDEADBEEF.
- Store 0xCAFEF00D to 0x54 (miss) -> both requests high, line installed with word 1 = 0xCAFEF00D; load 0x54 returns 0xCAFEF00D; memory word 0x54 also updated.
- Load 0x24 then 0xA4 (same index, NUM_SETS=8) -> second access misses and evicts; reload of 0x24 misses again.
- Rst asserted 5 cycles into a FILL -> next cycle all outputs 0, state IDLE; the subsequent MemReadReady is ignored; load 0x24 misses (valid cleared).

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared definitions for the L1 data cache: FSM encoding and geometry helpers.
package dcache_pkg;

  localparam int unsigned WORD_W            = 32;
  localparam int unsigned BYTE_OFS_W        = 2;
  localparam int unsigned DCACHE_NUM_SETS   = 8;
  localparam int unsigned DCACHE_BLOCK_SIZE = 4;

  // Width of the word-offset field for a given block size
  function automatic int unsigned calc_offset_w(input int unsigned block_size);
    return $clog2(block_size);
  endfunction

  // Width of the set-index field for a given number of sets
  function automatic int unsigned calc_index_w(input int unsigned num_sets);
    return $clog2(num_sets);
  endfunction

  // Remaining upper address bits form the tag
  function automatic int unsigned calc_tag_w(input int unsigned num_sets,
                                             input int unsigned block_size);
    return WORD_W - calc_index_w(num_sets) - calc_offset_w(block_size) - BYTE_OFS_W;
  endfunction

  localparam int unsigned OFFSET_W = calc_offset_w(DCACHE_BLOCK_SIZE);
  localparam int unsigned INDEX_W  = calc_index_w(DCACHE_NUM_SETS);
  localparam int unsigned TAG_W    = calc_tag_w(DCACHE_NUM_SETS, DCACHE_BLOCK_SIZE);
  localparam int unsigned LINE_W   = WORD_W * DCACHE_BLOCK_SIZE;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FILL       = 3'd1,
    WRITE      = 3'd2,
    FILL_WRITE = 3'd3,
    RESUME     = 3'd4
  } state_t;

endpackage

// File: rtl/dcache_line_array.sv
// Valid/tag/data storage for the direct-mapped data cache.
// Asynchronous read by index; synchronous full-line fill and single-word write.
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_SETS   = DCACHE_NUM_SETS,
  parameter int unsigned BLOCK_SIZE = DCACHE_BLOCK_SIZE
) (
  input  logic                                              Clk,
  input  logic                                              Rst,
  input  logic [calc_index_w(NUM_SETS)-1:0]                 RdIndex,
  output logic                                              RdValid,
  output logic [calc_tag_w(NUM_SETS, BLOCK_SIZE)-1:0]       RdTag,
  output logic [WORD_W*BLOCK_SIZE-1:0]                      RdLine,
  input  logic                                              FillEn,
  input  logic [calc_index_w(NUM_SETS)-1:0]                 FillIndex,
  input  logic [calc_tag_w(NUM_SETS, BLOCK_SIZE)-1:0]       FillTag,
  input  logic [WORD_W*BLOCK_SIZE-1:0]                      FillLine,
  input  logic                                              WordEn,
  input  logic [calc_index_w(NUM_SETS)-1:0]                 WordIndex,
  input  logic [calc_offset_w(BLOCK_SIZE)-1:0]              WordOffset,
  input  logic [WORD_W-1:0]                                 WordData
);

  localparam int unsigned OFFSET_BITS = calc_offset_w(BLOCK_SIZE);
  localparam int unsigned TAG_BITS    = calc_tag_w(NUM_SETS, BLOCK_SIZE);
  localparam int unsigned LINE_BITS   = WORD_W * BLOCK_SIZE;

  logic [NUM_SETS-1:0]  valid_q;
  logic [TAG_BITS-1:0]  tag_q  [NUM_SETS];
  logic [LINE_BITS-1:0] data_q [NUM_SETS];

  // Combinational lookup of the addressed line
  assign RdValid = valid_q[RdIndex];
  assign RdTag   = tag_q[RdIndex];
  assign RdLine  = data_q[RdIndex];

  // Valid bits: cleared on reset, set when a line is installed
  always_ff @(posedge Clk) begin
    if (Rst) begin
      valid_q <= '0;
    end else if (FillEn) begin
      valid_q[FillIndex] <= 1'b1;
    end
  end

  // Tag and data storage: full-line install or single-word store update
  always_ff @(posedge Clk) begin
    if (FillEn) begin
      tag_q[FillIndex]  <= FillTag;
      data_q[FillIndex] <= FillLine;
    end else if (WordEn) begin
      for (int w = 0; w < BLOCK_SIZE; w++) begin
        if (WordOffset == OFFSET_BITS'(w)) begin
          data_q[WordIndex][w*WORD_W +: WORD_W] <= WordData;
        end
      end
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, write-allocate L1 data cache between the MEM
// stage and the block-read data memory. Load hits are served in the access cycle;
// fills and write-throughs freeze the pipeline via Stall.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module data_cache
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_SETS   = DCACHE_NUM_SETS,
  parameter int unsigned BLOCK_SIZE = DCACHE_BLOCK_SIZE
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [31:0]                  Address,
  input  logic                         MemRead,
  input  logic                         MemWrite,
  input  logic [31:0]                  WriteData,
  output logic [31:0]                  ReadData,
  output logic                         Stall,
  output logic [31:0]                  MemAddress,
  output logic                         MemReadMiss,
  output logic                         MemWriteThrough,
  output logic [31:0]                  MemWriteData,
  input  logic [32*BLOCK_SIZE-1:0]     MemReadData,
  input  logic                         MemReadReady,
  input  logic                         MemWriteReady
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]                  HitCount,
  output logic [31:0]                  MissCount
`endif
);

  localparam int unsigned OFFSET_BITS = calc_offset_w(BLOCK_SIZE);
  localparam int unsigned INDEX_BITS  = calc_index_w(NUM_SETS);
  localparam int unsigned TAG_BITS    = calc_tag_w(NUM_SETS, BLOCK_SIZE);
  localparam int unsigned LINE_BITS   = WORD_W * BLOCK_SIZE;
  localparam int unsigned INDEX_LSB   = BYTE_OFS_W + OFFSET_BITS;
  localparam int unsigned TAG_LSB     = INDEX_LSB + INDEX_BITS;

  state_t state;
  // High for the single IDLE cycle in which the stalled instruction is replayed
  logic   replay;

  logic [OFFSET_BITS-1:0] req_offset;
  logic [INDEX_BITS-1:0]  req_index;
  logic [TAG_BITS-1:0]    req_tag;
  logic [OFFSET_BITS-1:0] lat_offset;
  logic [INDEX_BITS-1:0]  lat_index;
  logic [TAG_BITS-1:0]    lat_tag;

  logic                   rd_valid;
  logic [TAG_BITS-1:0]    rd_tag;
  logic [LINE_BITS-1:0]   rd_line;
  logic                   hit;
  logic [WORD_W-1:0]      hit_word;

  logic                   fill_en;
  logic [LINE_BITS-1:0]   fill_line;
  logic                   word_en;
  logic                   unused_addr_lsb;

  assign req_offset = Address[BYTE_OFS_W +: OFFSET_BITS];
  assign req_index  = Address[INDEX_LSB +: INDEX_BITS];
  assign req_tag    = Address[TAG_LSB +: TAG_BITS];
  assign lat_offset = MemAddress[BYTE_OFS_W +: OFFSET_BITS];
  assign lat_index  = MemAddress[INDEX_LSB +: INDEX_BITS];
  assign lat_tag    = MemAddress[TAG_LSB +: TAG_BITS];
  assign unused_addr_lsb = ^Address[BYTE_OFS_W-1:0];

  assign hit     = rd_valid && (rd_tag == req_tag);
  assign fill_en = ((state == FILL) || (state == FILL_WRITE)) && MemReadReady;
  assign word_en = (state == IDLE) && MemWrite && !replay && hit;

  dcache_line_array #(
    .NUM_SETS   (NUM_SETS),
    .BLOCK_SIZE (BLOCK_SIZE)
  ) u_lines (
    .Clk        (Clk),
    .Rst        (Rst),
    .RdIndex    (req_index),
    .RdValid    (rd_valid),
    .RdTag      (rd_tag),
    .RdLine     (rd_line),
    .FillEn     (fill_en),
    .FillIndex  (lat_index),
    .FillTag    (lat_tag),
    .FillLine   (fill_line),
    .WordEn     (word_en),
    .WordIndex  (req_index),
    .WordOffset (req_offset),
    .WordData   (WriteData)
  );

  // Select the addressed word out of the looked-up line
  always_comb begin
    hit_word = '0;
    for (int w = 0; w < BLOCK_SIZE; w++) begin
      if (req_offset == OFFSET_BITS'(w)) begin
        hit_word = rd_line[w*WORD_W +: WORD_W];
      end
    end
  end

  // Returned block, with the pending store word merged in on a store miss
  always_comb begin
    fill_line = MemReadData;
    if (state == FILL_WRITE) begin
      for (int w = 0; w < BLOCK_SIZE; w++) begin
        if (lat_offset == OFFSET_BITS'(w)) begin
          fill_line[w*WORD_W +: WORD_W] = MemWriteData;
        end
      end
    end
  end

  // Pipeline-facing response: same-cycle load data and stall decision
  always_comb begin
    Stall    = 1'b0;
    ReadData = '0;
    if (state != IDLE) begin
      Stall = 1'b1;
    end else if (MemWrite) begin
      // a replayed store already completed its write; let it retire
      Stall = !replay;
    end else if (MemRead) begin
      if (hit) begin
        ReadData = hit_word;
      end else begin
        Stall = 1'b1;
      end
    end
  end

  // Control FSM with registered memory requests and latched address/data
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state           <= IDLE;
      replay          <= 1'b0;
      MemReadMiss     <= 1'b0;
      MemWriteThrough <= 1'b0;
      MemAddress      <= '0;
      MemWriteData    <= '0;
    end else begin
      replay <= 1'b0;
      case (state)
        IDLE: begin
          if (MemWrite && !replay) begin
            MemAddress      <= Address;
            MemWriteData    <= WriteData;
            MemWriteThrough <= 1'b1;
            if (hit) begin
              state <= WRITE;
            end else begin
              MemReadMiss <= 1'b1;
              state       <= FILL_WRITE;
            end
          end else if (MemRead && !MemWrite && !hit) begin
            MemAddress  <= Address;
            MemReadMiss <= 1'b1;
            state       <= FILL;
          end
        end
        FILL: begin
          if (MemReadReady) begin
            MemReadMiss <= 1'b0;
            state       <= RESUME;
          end
        end
        WRITE: begin
          if (MemWriteReady) begin
            MemWriteThrough <= 1'b0;
            state           <= RESUME;
          end
        end
        FILL_WRITE: begin
          if (MemReadReady) begin
            MemReadMiss     <= 1'b0;
            MemWriteThrough <= 1'b0;
            state           <= RESUME;
          end
        end
        RESUME: begin
          replay <= 1'b1;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  // Count first-issue IDLE accesses by outcome; replays are excluded
  always_ff @(posedge Clk) begin
    if (Rst) begin
      HitCount  <= '0;
      MissCount <= '0;
    end else if ((state == IDLE) && !replay && (MemRead || MemWrite)) begin
      if (hit) begin
        HitCount <= HitCount + 32'd1;
      end else begin
        MissCount <= MissCount + 32'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_data_cache.sv
// Directed self-checking bench for data_cache with a 20-cycle block-read memory model.
module tb_data_cache;

  localparam int unsigned MEM_LAT = 20;

  logic         Clk = 1'b0;
  logic         Rst;
  logic [31:0]  Address;
  logic         MemRead;
  logic         MemWrite;
  logic [31:0]  WriteData;
  logic [31:0]  ReadData;
  logic         Stall;
  logic [31:0]  MemAddress;
  logic         MemReadMiss;
  logic         MemWriteThrough;
  logic [31:0]  MemWriteData;
  logic [127:0] MemReadData   = '0;
  logic         MemReadReady  = 1'b0;
  logic         MemWriteReady = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0]  HitCount;
  logic [31:0]  MissCount;
`endif

  int checks   = 0;
  int failures = 0;

  data_cache dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .Address         (Address),
    .MemRead         (MemRead),
    .MemWrite        (MemWrite),
    .WriteData       (WriteData),
    .ReadData        (ReadData),
    .Stall           (Stall),
    .MemAddress      (MemAddress),
    .MemReadMiss     (MemReadMiss),
    .MemWriteThrough (MemWriteThrough),
    .MemWriteData    (MemWriteData),
    .MemReadData     (MemReadData),
    .MemReadReady    (MemReadReady),
    .MemWriteReady   (MemWriteReady)
`ifdef DCACHE_STATS_EN
    ,
    .HitCount        (HitCount),
    .MissCount       (MissCount)
`endif
  );

  always #5 Clk = ~Clk;

  // Data memory model: word-addressed, fixed latency, one-cycle Ready pulses
  logic [31:0] mem [64];
  bit          m_init = 1'b0;
  bit          m_busy = 1'b0;
  int          m_cnt  = 0;
  bit          m_rd, m_wr;
  logic [31:0] m_addr, m_data;
  logic [127:0] m_blk;

  always @(negedge Clk) begin
    if (!m_init) begin
      for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | 32'(i * 4);
      mem[9] = 32'h1111_2222;
      m_init = 1'b1;
    end
    MemReadReady  = 1'b0;
    MemWriteReady = 1'b0;
    if (!m_busy) begin
      if (MemReadMiss || MemWriteThrough) begin
        m_busy = 1'b1;
        m_cnt  = 0;
        m_rd   = MemReadMiss;
        m_wr   = MemWriteThrough;
        m_addr = MemAddress;
        m_data = MemWriteData;
      end
    end else begin
      m_cnt++;
      if (m_cnt == int'(MEM_LAT)) begin
        if (m_wr) mem[m_addr[7:2]] = m_data;
        if (m_rd) begin
          for (int w = 0; w < 4; w++) m_blk[w*32 +: 32] = mem[{m_addr[7:4], 2'(w)}];
          MemReadData  = m_blk;
          MemReadReady = 1'b1;
        end else begin
          MemWriteReady = 1'b1;
        end
        m_busy = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
    end
  endtask

  // One pipeline access held until the cache releases it
  task automatic do_op(input string tag, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input bit exp_rreq, input bit exp_wreq,
                       input logic [31:0] exp_rdata);
    bit held;
    bit seen;
    @(negedge Clk);
    Address = addr; MemRead = rd; MemWrite = wr; WriteData = wdata;
    #1;
    check(tag, "stall_access", 32'(Stall), 32'(exp_rreq | exp_wreq));
    if (exp_rreq || exp_wreq) begin
      @(negedge Clk); #1;
      check(tag, "req_rd", 32'(MemReadMiss), 32'(exp_rreq));
      check(tag, "req_wt", 32'(MemWriteThrough), 32'(exp_wreq));
      check(tag, "mem_addr", MemAddress, addr);
      if (exp_wreq) check(tag, "mem_wdata", MemWriteData, wdata);
      held = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
        @(negedge Clk); #1;
        held &= (MemReadMiss === exp_rreq) && (MemWriteThrough === exp_wreq) &&
                (Stall === 1'b1) && (MemAddress === addr);
        seen = MemReadReady || MemWriteReady;
      end
      check(tag, "req_held", 32'(held), 32'd1);
      check(tag, "ready_seen", 32'(seen), 32'd1);
      @(negedge Clk); #1;
      check(tag, "resume", 32'({Stall, MemReadMiss, MemWriteThrough}), 32'b100);
      @(negedge Clk); #1;
      check(tag, "replay_stall", 32'(Stall), 32'd0);
    end else begin
      check(tag, "no_req", 32'({MemReadMiss, MemWriteThrough}), 32'd0);
    end
    if (rd && !wr) check(tag, "rdata", ReadData, exp_rdata);
  endtask

  task automatic idle(input string tag);
    @(negedge Clk);
    MemRead = 1'b0; MemWrite = 1'b0; Address = 32'hFFFF_FFF0; WriteData = '0;
    #1;
    check(tag, "idle_stall", 32'(Stall), 32'd0);
    check(tag, "idle_rdata", ReadData, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    bit quiet;
    Rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Address = '0; WriteData = '0;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    #1;
    check("reset", "stall", 32'(Stall), 32'd0);
    check("reset", "rdata", ReadData, 32'd0);
    check("reset", "reqs", 32'({MemReadMiss, MemWriteThrough}), 32'd0);
    check("reset", "mem_addr", MemAddress, 32'd0);

    do_op("ld24_miss", 1, 0, 32'h24, '0, 1, 0, 32'h1111_2222);
    do_op("ld20_hit",  1, 0, 32'h20, '0, 0, 0, 32'hC0DE_0020);
    idle("after_hit");
    do_op("st28_hit",  0, 1, 32'h28, 32'hDEAD_BEEF, 0, 1, '0);
    idle("after_st28");
    check("st28", "mem_word", mem[10], 32'hDEAD_BEEF);
    do_op("ld28_hit",  1, 0, 32'h28, '0, 0, 0, 32'hDEAD_BEEF);
    do_op("rdwr2c",    1, 1, 32'h2C, 32'h1234_5678, 0, 1, '0);
    idle("after_rdwr");
    do_op("ld2c_hit",  1, 0, 32'h2C, '0, 0, 0, 32'h1234_5678);
    do_op("st54_miss", 0, 1, 32'h54, 32'hCAFE_F00D, 1, 1, '0);
    idle("after_st54");
    check("st54", "mem_word", mem[21], 32'hCAFE_F00D);
    do_op("ld54_hit",  1, 0, 32'h54, '0, 0, 0, 32'hCAFE_F00D);
    do_op("ld50_hit",  1, 0, 32'h50, '0, 0, 0, 32'hC0DE_0050);
    do_op("ld24_hit",  1, 0, 32'h24, '0, 0, 0, 32'h1111_2222);
    do_op("lda4_evict",1, 0, 32'hA4, '0, 1, 0, 32'hC0DE_00A4);
    do_op("ld24_again",1, 0, 32'h24, '0, 1, 0, 32'h1111_2222);
    do_op("ld2c_wt",   1, 0, 32'h2C, '0, 0, 0, 32'h1234_5678);
    idle("before_rst");

    // Reset five cycles into a fill
    @(negedge Clk);
    Address = 32'h34; MemRead = 1'b1;
    #1;
    check("rst_fill", "stall_access", 32'(Stall), 32'd1);
    repeat (5) @(negedge Clk);
    Rst = 1'b1; MemRead = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    check("rst_fill", "stall", 32'(Stall), 32'd0);
    check("rst_fill", "reqs", 32'({MemReadMiss, MemWriteThrough}), 32'd0);
    check("rst_fill", "rdata", ReadData, 32'd0);
    check("rst_fill", "mem_addr", MemAddress, 32'd0);
    seen  = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge Clk); #1;
      quiet &= (Stall === 1'b0) && (MemReadMiss === 1'b0) && (MemWriteThrough === 1'b0);
      seen = MemReadReady;
    end
    check("rst_fill", "late_ready_seen", 32'(seen), 32'd1);
    @(negedge Clk); #1;
    quiet &= (Stall === 1'b0) && (MemReadMiss === 1'b0) && (MemWriteThrough === 1'b0);
    check("rst_fill", "late_ready_ignored", 32'(quiet), 32'd1);
    do_op("ld24_postrst", 1, 0, 32'h24, '0, 1, 0, 32'h1111_2222);
    idle("end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
